mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory port between two requesters: port A (core control FSM: fetch, load, store) and port B (debug loader / program-image DMA).
- Each requester issues one-cycle read/write pulses and waits for a resp pulse. Downstream memory uses a level protocol: mem_read/mem_write held until mem_resp.
- Latches pulses, arbitrates round-robin, owns the memory bus until completion, and returns resp plus registered rdata to the owner.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 1024, cycles a granted transaction may wait for mem_resp before timeout_err is set

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- a_read  in  1  port A read pulse
- a_write  in  1  port A write pulse
- a_addr  in  AW  port A address, sampled with pulse
- a_wdata  in  DW  port A write data, sampled with pulse
- a_resp  out  1  port A completion pulse
- a_rdata  out  DW  port A read data, registered
- b_read, b_write, b_addr, b_wdata, b_resp, b_rdata  (same directions and widths as the A signals)  port B equivalents
- mem_read  out  1  downstream read level
- mem_write  out  1  downstream write level
- mem_addr  out  AW  downstream address
- mem_wdata  out  DW  downstream write data
- mem_rdata  in  DW  downstream read data, valid with mem_resp
- mem_resp  in  1  downstream completion pulse
- proto_err  out  1  sticky: illegal request pulse dropped
- timeout_err  out  1  sticky: TIMEOUT exceeded

Behaviour:
- Reset: all outputs 0, both pending slots empty, state IDLE, rr pointer favours A. Reset mid-transaction abandons it silently; no resp is issued.
- Pending slot per port:
  - A read or write pulse sets pending and captures op/addr/wdata at that edge.
  - Slot clears at the edge ending the cycle its resp is issued.
  - A pulse in the same cycle as that port's resp is legal; set wins.
- Illegal pulses set proto_err and are dropped without disturbing the existing slot:
  - a pulse while that port's slot is already pending (other than the resp cycle above);
  - read and write asserted together.
- FSM states IDLE, BUSY_A, BUSY_B:
  - IDLE: mem_read = mem_write = 0. If exactly one slot is pending, go to that BUSY_x. If both are pending, go to the port the rr pointer favours.
  - BUSY_x: mem_read/mem_write/mem_addr/mem_wdata are registered copies of slot x, stable the whole state. On mem_resp go to IDLE and flip the rr pointer to favour the other port.
- Latency:
  - Pulse in cycle N → earliest mem_read/mem_write high in cycle N+2.
  - mem_resp in cycle M → x_resp high in cycle M (combinational, gated by owner); x_rdata = mem_rdata captured at end of M, valid from M+1 until that port's next read completion. Writes do not update rdata.
  - Minimum one idle cycle between consecutive memory transactions.
- mem_resp while IDLE: ignored, no resp to either port, no error.
- Timeout: a counter clears on entry to BUSY_x and increments each BUSY cycle without mem_resp. At TIMEOUT it sets timeout_err and saturates; the transaction continues to wait.
- Sticky errors clear only on reset.

Decomposition:
- Shared package gets: mem_op_t (MEM_RD, MEM_WR), arb_state_t (IDLE, BUSY_A, BUSY_B), and a mem_req_t struct (op, addr, wdata).
- One natural sub-module: mem_req_slot. It holds the pending bit, captured request, proto_err detect and the rdata register, and is instantiated once per port.

Test Plan:
- A read pulse at cycle 0 to addr 0x100; memory responds 3 cycles after mem_read rises with 0xDEADBEEF → mem_read high cycles 2..5, mem_addr = 0x100, a_resp in cycle 5, a_rdata = 0xDEADBEEF from cycle 6, b_resp never.
- A and B pulses in the same cycle (A read 0x0, B write 0x40 / 0x55) → A served first, one idle cycle, then mem_write with addr 0x40 / wdata 0x55. A second simultaneous pair is served B first.
- B write pending while A issues 3 back-to-back reads, each new A pulse in its resp cycle → grants alternate A, B, A, A, A; nothing dropped.
- A read pulse while the A slot is already pending → proto_err = 1, original address still issued; a_read with a_write both high → proto_err, no transaction.
- TIMEOUT = 8, memory never responds → timeout_err rises after 8 BUSY cycles and mem_read stays high. A later mem_resp completes normally.
- rst_n low during BUSY_A → next cycle mem_read = 0, slots empty, no a_resp; a fresh request works normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
// Request fields are sized for address/data widths up to 32 bits.
package mem_arbiter_pkg;

    localparam int REQ_AW = 32;
    localparam int REQ_DW = 32;

    typedef enum logic {
        MEM_RD = 1'b0,
        MEM_WR = 1'b1
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } arb_state_t;

    typedef struct packed {
        mem_op_t             op;
        logic [REQ_AW-1:0]   addr;
        logic [REQ_DW-1:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_req_slot.sv
// One requester's pending slot: latches a pulse, flags illegal pulses,
// and keeps the last read data returned to this requester.
module mem_req_slot
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          resp,
    input  logic [DW-1:0] mem_rdata,
    output logic          pending,
    output mem_req_t      req,
    output logic [DW-1:0] rdata,
    output logic          proto_err
);

    logic pulse;
    logic accept;

    assign pulse  = rd | wr;
    // A new pulse is only legal into an empty slot or one being retired now.
    assign accept = pulse && !(rd && wr) && (!pending || resp);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            req       <= '0;
            rdata     <= '0;
            proto_err <= 1'b0;
        end else begin
            if (accept) begin
                pending   <= 1'b1;
                req.op    <= wr ? MEM_WR : MEM_RD;
                req.addr  <= REQ_AW'(addr);
                req.wdata <= REQ_DW'(wdata);
            end else if (resp) begin
                pending <= 1'b0;
            end
            if (pulse && !accept) begin
                proto_err <= 1'b1;
            end
            if (resp && req.op == MEM_RD) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter onto a single level-protocol memory port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_read,
    input  logic          a_write,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_resp,
    output logic [DW-1:0] a_rdata,
    input  logic          b_read,
    input  logic          b_write,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_resp,
    output logic [DW-1:0] b_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_resp,
    output logic          proto_err,
    output logic          timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t    state;
    logic          rr_b;
    logic [CW-1:0] wait_cnt;
    logic          a_pend;
    logic          b_pend;
    logic          a_perr;
    logic          b_perr;
    mem_req_t      a_req;
    mem_req_t      b_req;
    mem_req_t      sel;
    logic          grant_a;
    logic          grant_b;

    mem_req_slot #(.AW(AW), .DW(DW)) u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd        (a_read),
        .wr        (a_write),
        .addr      (a_addr),
        .wdata     (a_wdata),
        .resp      (a_resp),
        .mem_rdata (mem_rdata),
        .pending   (a_pend),
        .req       (a_req),
        .rdata     (a_rdata),
        .proto_err (a_perr)
    );

    mem_req_slot #(.AW(AW), .DW(DW)) u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd        (b_read),
        .wr        (b_write),
        .addr      (b_addr),
        .wdata     (b_wdata),
        .resp      (b_resp),
        .mem_rdata (mem_rdata),
        .pending   (b_pend),
        .req       (b_req),
        .rdata     (b_rdata),
        .proto_err (b_perr)
    );

    assign a_resp    = rst_n && mem_resp && (state == BUSY_A);
    assign b_resp    = rst_n && mem_resp && (state == BUSY_B);
    assign proto_err = a_perr | b_perr;

    // rr_b set means B wins a tie.
    assign grant_a = a_pend && (!b_pend || !rr_b);
    assign grant_b = b_pend && !grant_a;
    assign sel     = grant_a ? a_req : b_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_b        <= 1'b0;
            wait_cnt    <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (grant_a || grant_b) begin
                        state     <= grant_a ? BUSY_A : BUSY_B;
                        mem_read  <= (sel.op == MEM_RD);
                        mem_write <= (sel.op == MEM_WR);
                        mem_addr  <= sel.addr[AW-1:0];
                        mem_wdata <= sel.wdata[DW-1:0];
                    end
                end
                BUSY_A, BUSY_B: begin
                    if (mem_resp) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        rr_b      <= (state == BUSY_A);
                    end else begin
                        if (wait_cnt != CW'(TIMEOUT)) begin
                            wait_cnt <= wait_cnt + CW'(1);
                        end
                        if (wait_cnt == CW'(TIMEOUT - 1)) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_read, a_write, b_read, b_write;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_resp, b_resp;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_read, mem_write, mem_resp;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        proto_err, timeout_err;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_read      (a_read),
        .a_write     (a_write),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .a_resp      (a_resp),
        .a_rdata     (a_rdata),
        .b_read      (b_read),
        .b_write     (b_write),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .b_resp      (b_resp),
        .b_rdata     (b_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .proto_err   (proto_err),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          p;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input int p, input logic rd, input logic wr,
                              input logic [31:0] ad, input logic [31:0] wd);
        if (p == 0) begin
            a_read = rd; a_write = wr; a_addr = ad; a_wdata = wd;
        end else begin
            b_read = rd; b_write = wr; b_addr = ad; b_wdata = wd;
        end
    endtask

    task automatic idle_in;
        drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset;
        idle_in;
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
        rst_n     = 1'b0;
        step;
        step;
        rst_n = 1'b1;
        step;
    endtask

    // Single transaction: pulse now, expect the bus two cycles later,
    // respond after lat cycles, then check the returned read data.
    task automatic do_txn(input int p, input logic rd, input logic wr,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input int lat, input logic [31:0] data,
                          input logic [31:0] exp_rd);
        drive_port(p, rd, wr, ad, wd);
        step;
        idle_in;
        chk("txn_not_yet", {mem_read, mem_write}, 2'b00);
        step;
        chk("txn_op", {mem_read, mem_write}, {rd, wr});
        chk("txn_addr", mem_addr, ad);
        if (wr) chk("txn_wdata", mem_wdata, wd);
        for (int i = 0; i < lat; i++) begin
            chk("txn_hold", {mem_read, mem_write, mem_addr}, {rd, wr, ad});
            chk("txn_no_resp", {a_resp, b_resp}, 2'b00);
            step;
        end
        mem_resp  = 1'b1;
        mem_rdata = data;
        #1;
        chk("txn_resp", {a_resp, b_resp}, (p == 0) ? 2'b10 : 2'b01);
        step;
        mem_resp  = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        chk("txn_released", {mem_read, mem_write}, 2'b00);
        chk("txn_rdata", (p == 0) ? a_rdata : b_rdata, exp_rd);
    endtask

    task automatic serve(input string nm, input int p, input logic wr,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input logic [31:0] data);
        chk({nm, "_op"}, {mem_read, mem_write}, {!wr, wr});
        chk({nm, "_addr"}, mem_addr, ad);
        if (wr) chk({nm, "_wdata"}, mem_wdata, wd);
        mem_resp  = 1'b1;
        mem_rdata = data;
        #1;
        chk({nm, "_resp"}, {a_resp, b_resp}, (p == 0) ? 2'b10 : 2'b01);
        step;
        mem_resp = 1'b0;
    endtask

    initial begin
        tbl[0] = '{0, 1'b1, 1'b0, 32'h100,  32'h0,        3, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1] = '{0, 1'b0, 1'b1, 32'h104,  32'h1234,     1, 32'hFFFF0000, 32'hDEADBEEF};
        tbl[2] = '{1, 1'b1, 1'b0, 32'h2000, 32'h0,        0, 32'hCAFEF00D, 32'hCAFEF00D};
        tbl[3] = '{0, 1'b1, 1'b0, 32'h108,  32'h0,        2, 32'h0BADF00D, 32'h0BADF00D};
        tbl[4] = '{1, 1'b0, 1'b1, 32'h2004, 32'hA5A5A5A5, 2, 32'h11111111, 32'hCAFEF00D};
        tbl[5] = '{1, 1'b1, 1'b0, 32'h2008, 32'h0,        1, 32'h76543210, 32'h76543210};

        do_reset;
        chk("rst_ctl", {a_resp, b_resp, mem_read, mem_write,
                        proto_err, timeout_err}, 6'b0);
        chk("rst_bus", {mem_addr, mem_wdata}, 64'h0);
        chk("rst_rdata", {a_rdata, b_rdata}, 64'h0);

        for (int i = 0; i < 6; i++) begin
            do_txn(tbl[i].p, tbl[i].rd, tbl[i].wr, tbl[i].addr,
                   tbl[i].wdata, tbl[i].lat, tbl[i].data, tbl[i].exp_rd);
        end

        // Simultaneous pair: A wins after reset, one idle cycle, then B.
        do_reset;
        drive_port(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive_port(1, 1'b0, 1'b1, 32'h40, 32'h55);
        step;
        idle_in;
        step;
        serve("pair1_a", 0, 1'b0, 32'h0, 32'h0, 32'h1111);
        chk("pair1_gap", {mem_read, mem_write}, 2'b00);
        step;
        serve("pair1_b", 1, 1'b1, 32'h40, 32'h55, 32'h0);
        chk("pair1_a_rdata", a_rdata, 32'h1111);
        do_txn(0, 1'b1, 1'b0, 32'h80, 32'h0, 0, 32'h2222, 32'h2222);
        // A was served last, so B wins the next tie.
        drive_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive_port(1, 1'b1, 1'b0, 32'h50, 32'h0);
        step;
        idle_in;
        step;
        serve("pair2_b", 1, 1'b0, 32'h50, 32'h0, 32'h3333);
        chk("pair2_gap", {mem_read, mem_write}, 2'b00);
        step;
        serve("pair2_a", 0, 1'b0, 32'h10, 32'h0, 32'h4444);
        chk("pair2_rdata", {a_rdata, b_rdata}, {32'h4444, 32'h3333});

        // B write waiting while A re-issues in every resp cycle.
        do_reset;
        begin : b2b
            int   exp_g [5];
            int   ng, a_left, age;
            logic prev;
            exp_g  = '{0, 1, 0, 0, 0};
            ng     = 0;
            a_left = 3;
            age    = 0;
            prev   = 1'b0;
            drive_port(0, 1'b1, 1'b0, 32'h300, 32'h0);
            drive_port(1, 1'b0, 1'b1, 32'h400, 32'h77);
            step;
            for (int c = 0; c < 100 && ng < 5; c++) begin
                idle_in;
                mem_resp = 1'b0;
                if (mem_read | mem_write) begin
                    if (!prev) begin
                        chk("b2b_grant", mem_write, exp_g[ng][0]);
                        age = 0;
                    end else begin
                        age++;
                    end
                    if (age == 1) begin
                        mem_resp  = 1'b1;
                        mem_rdata = 32'(c);
                        if (!mem_write && a_left > 0) begin
                            drive_port(0, 1'b1, 1'b0,
                                       32'h300 + 32'(4 * (4 - a_left)), 32'h0);
                            a_left--;
                        end
                        #1;
                        chk("b2b_resp", {a_resp, b_resp},
                            mem_write ? 2'b01 : 2'b10);
                        ng++;
                    end
                end
                prev = mem_read | mem_write;
                step;
            end
            idle_in;
            mem_resp = 1'b0;
            chk("b2b_grants", ng, 5);
            chk("b2b_all_issued", a_left, 0);
            chk("b2b_no_proto", proto_err, 1'b0);
        end

        // Randomized traffic against a transaction-level model.
        do_reset;
        begin : rnd
            logic        out [2];
            logic        wrop [2];
            logic [31:0] raddr [2];
            logic [31:0] rwd [2];
            logic [31:0] erd [2];
            int          pcyc [2];
            logic        np [2];
            logic        nwr [2];
            logic [31:0] nad [2];
            logic [31:0] nwd [2];
            int          owner, last_owner, last_resp, lat, age, c;
            logic        busy, pa, pb, rsp [2];
            for (int p = 0; p < 2; p++) begin
                out[p] = 1'b0; wrop[p] = 1'b0; raddr[p] = 0; rwd[p] = 0;
                erd[p] = 0; pcyc[p] = -100;
            end
            owner      = -1;
            last_owner = 1;
            last_resp  = -100;
            lat        = 0;
            age        = 0;
            c          = 0;
            while (c < 2000 && (c < 400 || out[0] || out[1] || owner >= 0)) begin
                chk("rnd_a_rdata", a_rdata, erd[0]);
                chk("rnd_b_rdata", b_rdata, erd[1]);
                busy = mem_read | mem_write;
                idle_in;
                mem_resp = 1'b0;
                if (busy && owner < 0) begin
                    pa = out[0] && (pcyc[0] <= c - 2);
                    pb = out[1] && (pcyc[1] <= c - 2);
                    chk("rnd_grant_pending", pa | pb, 1'b1);
                    chk("rnd_gap", (c - last_resp) >= 2, 1'b1);
                    owner = (pa && pb) ? 1 - last_owner : (pb ? 1 : 0);
                    lat   = $urandom_range(0, 4);
                    age   = 0;
                end
                if (busy) begin
                    chk("rnd_op", {mem_read, mem_write},
                        {!wrop[owner], wrop[owner]});
                    chk("rnd_addr", mem_addr, raddr[owner]);
                    if (wrop[owner]) chk("rnd_wdata", mem_wdata, rwd[owner]);
                    if (age == lat) begin
                        mem_resp  = 1'b1;
                        mem_rdata = $urandom;
                    end
                    age++;
                end else if ($urandom_range(0, 7) == 0) begin
                    mem_resp  = 1'b1;
                    mem_rdata = $urandom;
                end
                rsp[0] = busy && mem_resp && owner == 0;
                rsp[1] = busy && mem_resp && owner == 1;
                for (int p = 0; p < 2; p++) begin
                    np[p] = c < 400 && (!out[p] || rsp[p])
                            && $urandom_range(0, 3) == 0;
                    nwr[p] = 1'($urandom_range(0, 1));
                    nad[p] = {p == 1, 31'($urandom)};
                    nwd[p] = $urandom;
                    if (np[p]) drive_port(p, !nwr[p], nwr[p], nad[p], nwd[p]);
                end
                #1;
                chk("rnd_resp", {a_resp, b_resp}, {rsp[0], rsp[1]});
                if (busy && mem_resp) begin
                    if (!wrop[owner]) erd[owner] = mem_rdata;
                    out[owner] = 1'b0;
                    last_owner = owner;
                    last_resp  = c;
                    owner      = -1;
                end
                for (int p = 0; p < 2; p++) begin
                    if (np[p]) begin
                        out[p]   = 1'b1;
                        wrop[p]  = nwr[p];
                        raddr[p] = nad[p];
                        rwd[p]   = nwd[p];
                        pcyc[p]  = c;
                    end
                end
                step;
                c++;
            end
            idle_in;
            mem_resp = 1'b0;
            chk("rnd_drain", {out[0], out[1]}, 2'b00);
            chk("rnd_no_err", {proto_err, timeout_err}, 2'b00);
        end

        // Second pulse into a pending slot is dropped and flagged.
        do_reset;
        drive_port(0, 1'b1, 1'b0, 32'h200, 32'h0);
        step;
        drive_port(0, 1'b1, 1'b0, 32'h300, 32'h0);
        step;
        idle_in;
        chk("perr_set", proto_err, 1'b1);
        serve("perr_orig", 0, 1'b0, 32'h200, 32'h0, 32'h5151);
        for (int i = 0; i < 4; i++) begin
            chk("perr_dropped", {mem_read, mem_write}, 2'b00);
            step;
        end
        do_reset;
        chk("perr_cleared", proto_err, 1'b0);
        drive_port(0, 1'b1, 1'b1, 32'h500, 32'h9);
        step;
        idle_in;
        chk("perr_rdwr", proto_err, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("perr_rdwr_no_txn", {mem_read, mem_write}, 2'b00);
            step;
        end

        // Memory stalls: timeout after 8 busy cycles, then late completion.
        do_reset;
        drive_port(0, 1'b1, 1'b0, 32'h600, 32'h0);
        step;
        idle_in;
        step;
        for (int k = 1; k <= 8; k++) begin
            chk("tmo_early", {mem_read, timeout_err}, 2'b10);
            step;
        end
        chk("tmo_set", {mem_read, timeout_err}, 2'b11);
        step;
        step;
        chk("tmo_still_waiting", {mem_read, mem_addr}, {1'b1, 32'h600});
        serve("tmo_late", 0, 1'b0, 32'h600, 32'h0, 32'h7777);
        chk("tmo_done", {mem_read, timeout_err}, 2'b01);
        chk("tmo_rdata", a_rdata, 32'h7777);

        // Reset while A owns the bus.
        drive_port(0, 1'b1, 1'b0, 32'h700, 32'h0);
        step;
        idle_in;
        step;
        chk("rst_mid_busy", mem_read, 1'b1);
        step;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_no_resp", {a_resp, b_resp}, 2'b00);
        step;
        rst_n = 1'b1;
        chk("rst_mid_clear", {mem_read, mem_write, timeout_err, proto_err}, 4'b0);
        chk("rst_mid_rdata", a_rdata, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("rst_mid_slot_empty", {mem_read, mem_write, a_resp}, 3'b0);
        end
        do_txn(0, 1'b1, 1'b0, 32'h704, 32'h0, 1, 32'h12345678, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
